// File: rtl/dec_round_last_pkg.sv
// Shared constants for the AES decryption last round.
//   STATE_W   : AES state width in bits
//   BYTE_W    : byte width in bits
//   NUM_BYTES : bytes per state
//   byte_idx  : column-major byte number of state element s(r,c)
package dec_round_last_pkg;

  localparam int STATE_W   = 128;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 16;

  function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
    return r + 4 * c;
  endfunction

endpackage

// File: rtl/dec_round_last_inv_sbox.sv
// AES inverse S-box, purely combinational.
//   a : input byte
//   q : InvSubBytes(a)
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] q
);

  always_comb begin
    q = '0;
    case (a)
      8'h00: q = 8'h52; 8'h01: q = 8'h09; 8'h02: q = 8'h6a; 8'h03: q = 8'hd5; 8'h04: q = 8'h30; 8'h05: q = 8'h36; 8'h06: q = 8'ha5; 8'h07: q = 8'h38;
      8'h08: q = 8'hbf; 8'h09: q = 8'h40; 8'h0a: q = 8'ha3; 8'h0b: q = 8'h9e; 8'h0c: q = 8'h81; 8'h0d: q = 8'hf3; 8'h0e: q = 8'hd7; 8'h0f: q = 8'hfb;
      8'h10: q = 8'h7c; 8'h11: q = 8'he3; 8'h12: q = 8'h39; 8'h13: q = 8'h82; 8'h14: q = 8'h9b; 8'h15: q = 8'h2f; 8'h16: q = 8'hff; 8'h17: q = 8'h87;
      8'h18: q = 8'h34; 8'h19: q = 8'h8e; 8'h1a: q = 8'h43; 8'h1b: q = 8'h44; 8'h1c: q = 8'hc4; 8'h1d: q = 8'hde; 8'h1e: q = 8'he9; 8'h1f: q = 8'hcb;
      8'h20: q = 8'h54; 8'h21: q = 8'h7b; 8'h22: q = 8'h94; 8'h23: q = 8'h32; 8'h24: q = 8'ha6; 8'h25: q = 8'hc2; 8'h26: q = 8'h23; 8'h27: q = 8'h3d;
      8'h28: q = 8'hee; 8'h29: q = 8'h4c; 8'h2a: q = 8'h95; 8'h2b: q = 8'h0b; 8'h2c: q = 8'h42; 8'h2d: q = 8'hfa; 8'h2e: q = 8'hc3; 8'h2f: q = 8'h4e;
      8'h30: q = 8'h08; 8'h31: q = 8'h2e; 8'h32: q = 8'ha1; 8'h33: q = 8'h66; 8'h34: q = 8'h28; 8'h35: q = 8'hd9; 8'h36: q = 8'h24; 8'h37: q = 8'hb2;
      8'h38: q = 8'h76; 8'h39: q = 8'h5b; 8'h3a: q = 8'ha2; 8'h3b: q = 8'h49; 8'h3c: q = 8'h6d; 8'h3d: q = 8'h8b; 8'h3e: q = 8'hd1; 8'h3f: q = 8'h25;
      8'h40: q = 8'h72; 8'h41: q = 8'hf8; 8'h42: q = 8'hf6; 8'h43: q = 8'h64; 8'h44: q = 8'h86; 8'h45: q = 8'h68; 8'h46: q = 8'h98; 8'h47: q = 8'h16;
      8'h48: q = 8'hd4; 8'h49: q = 8'ha4; 8'h4a: q = 8'h5c; 8'h4b: q = 8'hcc; 8'h4c: q = 8'h5d; 8'h4d: q = 8'h65; 8'h4e: q = 8'hb6; 8'h4f: q = 8'h92;
      8'h50: q = 8'h6c; 8'h51: q = 8'h70; 8'h52: q = 8'h48; 8'h53: q = 8'h50; 8'h54: q = 8'hfd; 8'h55: q = 8'hed; 8'h56: q = 8'hb9; 8'h57: q = 8'hda;
      8'h58: q = 8'h5e; 8'h59: q = 8'h15; 8'h5a: q = 8'h46; 8'h5b: q = 8'h57; 8'h5c: q = 8'ha7; 8'h5d: q = 8'h8d; 8'h5e: q = 8'h9d; 8'h5f: q = 8'h84;
      8'h60: q = 8'h90; 8'h61: q = 8'hd8; 8'h62: q = 8'hab; 8'h63: q = 8'h00; 8'h64: q = 8'h8c; 8'h65: q = 8'hbc; 8'h66: q = 8'hd3; 8'h67: q = 8'h0a;
      8'h68: q = 8'hf7; 8'h69: q = 8'he4; 8'h6a: q = 8'h58; 8'h6b: q = 8'h05; 8'h6c: q = 8'hb8; 8'h6d: q = 8'hb3; 8'h6e: q = 8'h45; 8'h6f: q = 8'h06;
      8'h70: q = 8'hd0; 8'h71: q = 8'h2c; 8'h72: q = 8'h1e; 8'h73: q = 8'h8f; 8'h74: q = 8'hca; 8'h75: q = 8'h3f; 8'h76: q = 8'h0f; 8'h77: q = 8'h02;
      8'h78: q = 8'hc1; 8'h79: q = 8'haf; 8'h7a: q = 8'hbd; 8'h7b: q = 8'h03; 8'h7c: q = 8'h01; 8'h7d: q = 8'h13; 8'h7e: q = 8'h8a; 8'h7f: q = 8'h6b;
      8'h80: q = 8'h3a; 8'h81: q = 8'h91; 8'h82: q = 8'h11; 8'h83: q = 8'h41; 8'h84: q = 8'h4f; 8'h85: q = 8'h67; 8'h86: q = 8'hdc; 8'h87: q = 8'hea;
      8'h88: q = 8'h97; 8'h89: q = 8'hf2; 8'h8a: q = 8'hcf; 8'h8b: q = 8'hce; 8'h8c: q = 8'hf0; 8'h8d: q = 8'hb4; 8'h8e: q = 8'he6; 8'h8f: q = 8'h73;
      8'h90: q = 8'h96; 8'h91: q = 8'hac; 8'h92: q = 8'h74; 8'h93: q = 8'h22; 8'h94: q = 8'he7; 8'h95: q = 8'had; 8'h96: q = 8'h35; 8'h97: q = 8'h85;
      8'h98: q = 8'he2; 8'h99: q = 8'hf9; 8'h9a: q = 8'h37; 8'h9b: q = 8'he8; 8'h9c: q = 8'h1c; 8'h9d: q = 8'h75; 8'h9e: q = 8'hdf; 8'h9f: q = 8'h6e;
      8'ha0: q = 8'h47; 8'ha1: q = 8'hf1; 8'ha2: q = 8'h1a; 8'ha3: q = 8'h71; 8'ha4: q = 8'h1d; 8'ha5: q = 8'h29; 8'ha6: q = 8'hc5; 8'ha7: q = 8'h89;
      8'ha8: q = 8'h6f; 8'ha9: q = 8'hb7; 8'haa: q = 8'h62; 8'hab: q = 8'h0e; 8'hac: q = 8'haa; 8'had: q = 8'h18; 8'hae: q = 8'hbe; 8'haf: q = 8'h1b;
      8'hb0: q = 8'hfc; 8'hb1: q = 8'h56; 8'hb2: q = 8'h3e; 8'hb3: q = 8'h4b; 8'hb4: q = 8'hc6; 8'hb5: q = 8'hd2; 8'hb6: q = 8'h79; 8'hb7: q = 8'h20;
      8'hb8: q = 8'h9a; 8'hb9: q = 8'hdb; 8'hba: q = 8'hc0; 8'hbb: q = 8'hfe; 8'hbc: q = 8'h78; 8'hbd: q = 8'hcd; 8'hbe: q = 8'h5a; 8'hbf: q = 8'hf4;
      8'hc0: q = 8'h1f; 8'hc1: q = 8'hdd; 8'hc2: q = 8'ha8; 8'hc3: q = 8'h33; 8'hc4: q = 8'h88; 8'hc5: q = 8'h07; 8'hc6: q = 8'hc7; 8'hc7: q = 8'h31;
      8'hc8: q = 8'hb1; 8'hc9: q = 8'h12; 8'hca: q = 8'h10; 8'hcb: q = 8'h59; 8'hcc: q = 8'h27; 8'hcd: q = 8'h80; 8'hce: q = 8'hec; 8'hcf: q = 8'h5f;
      8'hd0: q = 8'h60; 8'hd1: q = 8'h51; 8'hd2: q = 8'h7f; 8'hd3: q = 8'ha9; 8'hd4: q = 8'h19; 8'hd5: q = 8'hb5; 8'hd6: q = 8'h4a; 8'hd7: q = 8'h0d;
      8'hd8: q = 8'h2d; 8'hd9: q = 8'he5; 8'hda: q = 8'h7a; 8'hdb: q = 8'h9f; 8'hdc: q = 8'h93; 8'hdd: q = 8'hc9; 8'hde: q = 8'h9c; 8'hdf: q = 8'hef;
      8'he0: q = 8'ha0; 8'he1: q = 8'he0; 8'he2: q = 8'h3b; 8'he3: q = 8'h4d; 8'he4: q = 8'hae; 8'he5: q = 8'h2a; 8'he6: q = 8'hf5; 8'he7: q = 8'hb0;
      8'he8: q = 8'hc8; 8'he9: q = 8'heb; 8'hea: q = 8'hbb; 8'heb: q = 8'h3c; 8'hec: q = 8'h83; 8'hed: q = 8'h53; 8'hee: q = 8'h99; 8'hef: q = 8'h61;
      8'hf0: q = 8'h17; 8'hf1: q = 8'h2b; 8'hf2: q = 8'h04; 8'hf3: q = 8'h7e; 8'hf4: q = 8'hba; 8'hf5: q = 8'h77; 8'hf6: q = 8'hd6; 8'hf7: q = 8'h26;
      8'hf8: q = 8'he1; 8'hf9: q = 8'h69; 8'hfa: q = 8'h14; 8'hfb: q = 8'h63; 8'hfc: q = 8'h55; 8'hfd: q = 8'h21; 8'hfe: q = 8'h0c; 8'hff: q = 8'h7d;
      default: q = '0;
    endcase
  end

endmodule

// File: rtl/dec_round_last.sv
// AES decryption last round: InvShiftRows -> InvSubBytes -> AddRoundKey,
// two registered stages with a travelling valid bit.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   key_we     : key-bus write strobe
//   addr       : key-bus address, accepted when equal to ADDRESS
//   rkey       : key-bus round-key data
//   in_valid   : din holds a valid state
//   din        : ciphertext-side state, byte 0 at [127:120], column-major
//   out_valid  : dout holds a valid state
//   dout       : plaintext-side state, same byte order
//   key_loaded : sticky flag, set by the first accepted key write
module dec_round_last
  import dec_round_last_pkg::*;
#(
  parameter logic [3:0] ADDRESS = 4'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_we,
  input  logic [3:0]         addr,
  input  logic [STATE_W-1:0] rkey,
  input  logic               in_valid,
  input  logic [STATE_W-1:0] din,
  output logic               out_valid,
  output logic [STATE_W-1:0] dout,
  output logic               key_loaded
);

  logic [STATE_W-1:0] key_q;
  logic [STATE_W-1:0] shifted;
  logic [STATE_W-1:0] subbed;
  logic [STATE_W-1:0] stage1_q;
  logic               v1;
  logic               key_hit;

  assign key_hit = key_we && (addr == ADDRESS);

  // InvShiftRows: row r rotates right by r, so out s(r,c) takes in s(r,(c-r) mod 4).
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign shifted[STATE_W-1-BYTE_W*byte_idx(r, c) -: BYTE_W] =
        din[STATE_W-1-BYTE_W*byte_idx(r, (c + 4 - r) % 4) -: BYTE_W];
    end
  end

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .a (shifted[STATE_W-1-BYTE_W*i -: BYTE_W]),
      .q (subbed[STATE_W-1-BYTE_W*i -: BYTE_W])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q      <= '0;
      key_loaded <= 1'b0;
    end else if (key_hit) begin
      key_q      <= rkey;
      key_loaded <= 1'b1;
    end
  end

  // Stage 2 reads key_q before this edge's write lands, so a write on the
  // same edge as the XOR only affects later states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage1_q  <= '0;
      v1        <= 1'b0;
      dout      <= '0;
      out_valid <= 1'b0;
    end else begin
      stage1_q  <= subbed;
      v1        <= in_valid;
      dout      <= stage1_q ^ key_q;
      out_valid <= v1;
    end
  end

endmodule

// File: tb/tb_dec_round_last.sv
module tb_dec_round_last;

  logic         clk;
  logic         rst;
  logic         key_we;
  logic [3:0]   addr;
  logic [127:0] rkey;
  logic         in_valid;
  logic [127:0] din;
  logic         out_valid;
  logic [127:0] dout;
  logic         key_loaded;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0]   inv_tab [256];
  logic [127:0] mkey;

  dec_round_last #(.ADDRESS(4'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_we     (key_we),
    .addr       (addr),
    .rkey       (rkey),
    .in_valid   (in_valid),
    .din        (din),
    .out_valid  (out_valid),
    .dout       (dout),
    .key_loaded (key_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model from GF(2^8) arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int b = 1; b < 256; b++)
      if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] get_b(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k);
    logic [127:0] o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = inv_tab[get_b(s, r + 4*((c - r + 4) % 4))];
    return o ^ k;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wkey(input logic [3:0] a, input logic [127:0] v);
    key_we = 1'b1;
    addr   = a;
    rkey   = v;
    tick();
    key_we = 1'b0;
    if (a == 4'd0) mkey = v;
  endtask

  // Single valid pulse, result checked exactly two edges later and gone one edge after.
  task automatic pulse(input string name, input logic [127:0] s, input logic [127:0] exp);
    in_valid = 1'b1;
    din      = s;
    tick();
    in_valid = 1'b0;
    din      = '0;
    chk({name, "_early"}, {127'd0, out_valid}, 128'd0);
    tick();
    chk({name, "_v"}, {127'd0, out_valid}, 128'd1);
    chk({name, "_d"}, dout, exp);
    tick();
    chk({name, "_vdrop"}, {127'd0, out_valid}, 128'd0);
  endtask

  task automatic run_stream(input string name, input int n, input bit all_valid);
    logic         hv [64];
    logic [127:0] hd [64];
    for (int j = 0; j < n + 2; j++) begin
      if (j < n) begin
        in_valid = all_valid ? 1'b1 : 1'($urandom_range(0, 1));
        din      = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        in_valid = 1'b0;
      end
      hv[j] = in_valid;
      hd[j] = model(din, mkey);
      tick();
      if (j >= 1) begin
        chk({name, "_v"}, {127'd0, out_valid}, {127'd0, hv[j-1]});
        if (hv[j-1]) chk({name, "_d"}, dout, hd[j-1]);
      end
    end
  endtask

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] state;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{"isbox63",  128'h0, {16{8'h63}}, 128'h0};
    vecs[1] = '{"isbox00",  {16{8'hff}}, 128'h0, {16{8'had}}};
    vecs[2] = '{"ishift",   128'h0,
                {8'h63, 8'h7c, {14{8'h63}}},
                128'h00000000_00010000_00000000_00000000};
    vecs[3] = '{"fips",     128'h000102030405060708090a0b0c0d0e0f,
                128'h6353e08c0960e104cd70b751bacad0e7,
                128'h00112233445566778899aabbccddeeff};

    for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);

    rst = 1'b0; key_we = 1'b0; addr = '0; rkey = '0; in_valid = 1'b0; din = '0;
    mkey = '0;
    #1;
    chk("por_valid", {127'd0, out_valid}, 128'd0);
    chk("por_dout", dout, 128'd0);
    chk("por_kl", {127'd0, key_loaded}, 128'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Table vectors
    for (int i = 0; i < 4; i++) begin
      wkey(4'd0, vecs[i].key);
      pulse(vecs[i].name, vecs[i].state, vecs[i].exp);
    end

    // Reset mid-stream
    in_valid = 1'b1;
    din      = {$urandom(), $urandom(), $urandom(), $urandom()};
    tick();
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_dout", dout, 128'd0);
    chk("rst_kl", {127'd0, key_loaded}, 128'd0);
    tick();
    chk("rst_hold_v", {127'd0, out_valid}, 128'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    mkey = '0;
    tick(); tick();
    chk("rst_post_v", {127'd0, out_valid}, 128'd0);
    chk("rst_post_kl", {127'd0, key_loaded}, 128'd0);
    wkey(4'd0, 128'h0);
    chk("load_kl", {127'd0, key_loaded}, 128'd1);

    // Address filter
    wkey(4'd3, {16{8'hff}});
    pulse("addr_filter", {16{8'h63}}, 128'h0);

    // Key/data collision: write lands at edge t+1 (same cycle as in_valid)
    in_valid = 1'b1; din = {16{8'h63}};
    key_we = 1'b1; addr = 4'd0; rkey = {16{8'h5a}};
    tick();
    key_we = 1'b0; in_valid = 1'b0; mkey = {16{8'h5a}};
    tick();
    chk("coll_t1_v", {127'd0, out_valid}, 128'd1);
    chk("coll_t1_d", dout, {16{8'h5a}});
    wkey(4'd0, 128'h0);
    tick();
    // Write lands at edge t+2: stage 2 still sees key 0
    in_valid = 1'b1; din = {16{8'h63}};
    tick();
    in_valid = 1'b0;
    key_we = 1'b1; addr = 4'd0; rkey = {16{8'h5a}};
    tick();
    key_we = 1'b0; mkey = {16{8'h5a}};
    chk("coll_t2_v", {127'd0, out_valid}, 128'd1);
    chk("coll_t2_d", dout, 128'h0);
    tick();

    // Streaming
    wkey(4'd0, {$urandom(), $urandom(), $urandom(), $urandom()});
    run_stream("b2b", 8, 1'b1);
    wkey(4'd0, {$urandom(), $urandom(), $urandom(), $urandom()});
    run_stream("rand", 40, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dec_round_last.md
Name: dec_round_last

Overview:
- Final round of AES decryption, the inverse counterpart of the encryption last round.
- Datapath order: InvShiftRows, then InvSubBytes, then AddRoundKey.
- Round key lives in a local register, written over the shared key bus only when addr matches the instance ADDRESS.
- Two-stage registered pipeline with a valid bit, so it chains behind the inverse middle rounds.

Parameters:
ADDRESS, 4'd0, key-bus address this instance responds to (round-key slot, normally 0 for the decryption last round).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset; asynchronous assert, active-low (0 = reset), synchronous deassert upstream.
key_we  input  1  round-key write strobe on the shared key bus.
addr  input  4  key-bus address; write accepted only when addr == ADDRESS.
rkey  input  128  round-key data on the key bus.
in_valid  input  1  din carries a valid state this cycle.
din  input  128  input state, column-major: din[127:120] = byte 0 = s(0,0), byte i = s(i%4, i/4).
out_valid  output  1  dout valid.
dout  output  128  plaintext state, same byte order.
key_loaded  output  1  at least one key write accepted since reset.

Behaviour:
- Reset (rst=0, asynchronous): key register = 0; key_loaded = 0; both stage registers = 0; stage valids = 0. Hence out_valid = 0 and dout = 0.
- Key write: at a rising edge with key_we=1 and addr==ADDRESS, the key register takes rkey and key_loaded goes to 1 (sticky until reset).
  - Writes with any other addr are ignored.
- Stage 1 (edge t+1 for input at cycle t):
  - InvShiftRows is combinational: out s(r,c) = in s(r,(c-r) mod 4), i.e. row r rotates right by r.
  - InvSubBytes applies the inverse S-box to all 16 bytes; the result is registered into stage1_q.
  - v1 <= in_valid.
- Stage 2 (edge t+2): dout <= stage1_q XOR key register; out_valid <= v1.
- Latency: exactly 2 cycles. Throughput: 1 state per cycle, no stall or backpressure.
- Data registers load every cycle regardless of valid; consumers must qualify dout with out_valid.
- Key/data collision: stage 2 uses the key register value held before edge t+2.
  - A key write at edge t+2 or later does not affect that state.
  - A write at edge t+1 or earlier does.
  - Key writes never disturb in-flight valids.
- in_valid while key_loaded=0: processed normally with key 0. No error, no blocking.
- Reset mid-operation: in-flight states are dropped; out_valid is 0 from the reset assertion until 2 edges after the first in_valid following release.
- Back-to-back valids: each is output on consecutive cycles, in order.

Decomposition:
- Shared package: AES state width (128), byte width, number of bytes (16), and the byte-index function r + 4c used by the shift permutation.
- Sub-module inv_sbox: 8-bit combinational inverse S-box (256-entry case table), instantiated 16 times in a generate loop.
  - It is reusable by the inverse middle rounds.
- The key register with address match stays local to this module.

Test Plan:
1. Reset then load: assert rst=0 mid-stream with in_valid=1 -> out_valid=0, dout=0, key_loaded=0 immediately. After release, key write with addr=0, rkey=0 -> key_loaded=1 next edge.
2. Inverse S-box: key=0, din=all bytes 0x63, in_valid pulse -> exactly 2 cycles later out_valid=1 for one cycle, dout=128'h0. Then din=all 0x00 with key=all 0xff -> dout=all bytes 0xad.
3. InvShiftRows: key=0, din all 0x63 except byte 1 (bits [119:112]) = 0x7c -> dout=128'h00000000_00010000_00000000_00000000 (0x01 lands at byte 5, s(1,1)).
4. Address filter: key_we=1, addr=4'd3, rkey=all 0xff with ADDRESS=0 -> key unchanged. Rerun scenario 2a -> dout still 0.
5. Key/data collision: in_valid at cycle t with din all 0x63. Key write of all 0x5a at edge t+1 -> dout all 0x5a. Same write at edge t+2 instead -> dout all 0x00.
6. Streaming: 8 consecutive valids with distinct states -> 8 consecutive out_valid cycles, in order, each matching the software model.
   - Include one FIPS-197 decryption last-round vector check.
